// File: rtl/irq_gateway_pkg.sv
// Shared definitions for the interrupt gateway: register offsets,
// per-source state encoding and the CLAIM "no interrupt" value.
package irq_gateway_pkg;

    localparam int ID_W = 5;

    localparam logic [3:0] OFF_PENDING  = 4'h0;
    localparam logic [3:0] OFF_TRIGGER  = 4'h4;
    localparam logic [3:0] OFF_CLAIM    = 4'h8;
    localparam logic [3:0] OFF_COMPLETE = 4'hC;

    localparam logic [ID_W-1:0] CLAIM_NONE = '0;

    typedef enum logic [1:0] {
        SRC_IDLE  = 2'd0,
        SRC_PEND  = 2'd1,
        SRC_INSVC = 2'd2
    } src_state_e;

    // A source's state is fully described by its pending and in-service bits.
    function automatic src_state_e src_state(input logic pend, input logic insvc);
        if (insvc) return SRC_INSVC;
        if (pend) return SRC_PEND;
        return SRC_IDLE;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source input conditioning: optional two-flop synchronizer
// (enabled by IRQ_SYNC_EN) followed by a rising-edge detector.
module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    output logic level,
    output logic rise
);

`ifdef IRQ_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], src};
        end
    end

    assign level = sync[1];
`else
    assign level = src;
`endif

    logic prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/irq_gateway.sv
// Interrupt gateway: edge/level capture, claim/complete handshake and
// registered MEI outputs. Define IRQ_SYNC_EN to synchronize raw inputs.
module irq_gateway
    import irq_gateway_pkg::*;
#(
    parameter int N_SRC = 6
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic [N_SRC-1:0] i_IRQ_SRC,
    input  logic             i_BUS_EN,
    input  logic             i_BUS_WE,
    input  logic [3:0]       i_BUS_ADDR,
    input  logic [31:0]      i_BUS_WDATA,
    output logic [31:0]      o_BUS_RDATA,
    output logic             o_BUS_ACK,
    output logic [N_SRC-1:0] o_MEI
);

    logic [N_SRC-1:0] lvl;
    logic [N_SRC-1:0] rise;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        irq_sync_edge u_sync (
            .clk   (i_CLK),
            .rst_n (i_RSTn),
            .src   (i_IRQ_SRC[g]),
            .level (lvl[g]),
            .rise  (rise[g])
        );
    end

    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] in_service;
    logic [N_SRC-1:0] trigger;

    logic [3:0]       off;
    logic             rd;
    logic             wr;
    logic             do_claim;
    logic             do_w1c;
    logic             do_trig;
    logic             do_cmp;
    logic [N_SRC-1:0] cand;
    logic [N_SRC-1:0] claim_oh;
    logic [ID_W-1:0]  claim_id;
    logic [N_SRC-1:0] cmp_oh;
    logic [N_SRC-1:0] set_vec;
    logic [N_SRC-1:0] pend_nxt;
    logic [N_SRC-1:0] insvc_nxt;
    logic [31:0]      rd_val;

    assign off      = i_BUS_ADDR & 4'hC;
    assign rd       = i_BUS_EN & ~i_BUS_WE;
    assign wr       = i_BUS_EN & i_BUS_WE;
    assign do_claim = rd && (off == OFF_CLAIM);
    assign do_w1c   = wr && (off == OFF_PENDING);
    assign do_trig  = wr && (off == OFF_TRIGGER);
    assign do_cmp   = wr && (off == OFF_COMPLETE);
    assign cand     = pending & ~in_service;

    // Scan downwards so the lowest eligible id is the one that sticks.
    always_comb begin
        claim_oh = '0;
        claim_id = CLAIM_NONE;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                claim_oh    = '0;
                claim_oh[i] = 1'b1;
                claim_id    = ID_W'(i + 1);
            end
        end
    end

    always_comb begin
        cmp_oh  = '0;
        set_vec = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cmp_oh[i]  = do_cmp && (i_BUS_WDATA == 32'(i + 1));
            set_vec[i] = trigger[i] ? rise[i] : lvl[i];
        end
    end

    // Clears are applied first so a coincident set always wins.
    always_comb begin
        pend_nxt = pending;
        if (do_claim) pend_nxt = pend_nxt & ~claim_oh;
        if (do_w1c) pend_nxt = pend_nxt & ~(i_BUS_WDATA[N_SRC-1:0] & trigger);
        pend_nxt = pend_nxt | set_vec;

        insvc_nxt = in_service;
        if (do_claim) insvc_nxt = insvc_nxt | claim_oh;
        insvc_nxt = insvc_nxt & ~cmp_oh;
    end

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_PENDING: rd_val = 32'(pending);
            OFF_TRIGGER: rd_val = 32'(trigger);
            OFF_CLAIM:   rd_val = 32'(claim_id);
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            pending     <= '0;
            in_service  <= '0;
            trigger     <= '0;
            o_MEI       <= '0;
            o_BUS_ACK   <= 1'b0;
            o_BUS_RDATA <= '0;
        end else begin
            pending     <= pend_nxt;
            in_service  <= insvc_nxt;
            if (do_trig) trigger <= i_BUS_WDATA[N_SRC-1:0];
            o_MEI       <= pending & ~in_service;
            o_BUS_ACK   <= i_BUS_EN;
            o_BUS_RDATA <= rd ? rd_val : '0;
        end
    end

endmodule

// File: tb/tb_irq_gateway.sv
// Self-checking bench for irq_gateway: bus read data goes through a
// scoreboard queue, MEI and reset behaviour are checked directly.
module tb_irq_gateway;
    import irq_gateway_pkg::*;

    localparam int N = 6;
`ifdef IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  irq   = '0;
    logic          en    = 1'b0;
    logic          we    = 1'b0;
    logic [3:0]    addr  = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          ack;
    logic [N-1:0]  mei;

    int            total = 0;
    int            bad   = 0;
    string         phase = "init";
    logic [31:0]   sb[$];

    irq_gateway #(.N_SRC(N)) dut (
        .i_CLK       (clk),
        .i_RSTn      (rst_n),
        .i_IRQ_SRC   (irq),
        .i_BUS_EN    (en),
        .i_BUS_WE    (we),
        .i_BUS_ADDR  (addr),
        .i_BUS_WDATA (wdata),
        .o_BUS_RDATA (rdata),
        .o_BUS_ACK   (ack),
        .o_MEI       (mei)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s [%s]: got=%0h want=%0h", tag, phase, got, exp);
        end
    endtask

    task automatic chk_mei(input logic [31:0] exp);
        chk("mei", 32'(mei), exp);
    endtask

    // Called at a falling edge; returns at the falling edge where ACK shows.
    task automatic bus_op(input logic w, input logic [3:0] a,
                          input logic [31:0] d, input logic [31:0] exp);
        en    = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        sb.push_back(exp);
        @(negedge clk);
        en    = 1'b0;
        we    = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp);
        bus_op(1'b0, a, 32'd0, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus_op(1'b1, a, d, 32'd0);
    endtask

    task automatic pulse(input logic [N-1:0] b);
        irq = irq | b;
        @(negedge clk);
        irq = irq & ~b;
        repeat (SYNC_LAT + 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (sb.size() == 0) chk("ack_spur", 32'(ack), 32'd0);
            else chk("rdata", rdata, sb.pop_front());
        end
    end

    initial begin
        phase = "reset";
        repeat (3) @(negedge clk);
        chk_mei(0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        rd(OFF_PENDING, 0);
        rd(OFF_TRIGGER, 0);
        rd(OFF_CLAIM, 0);

        phase = "edge3";
        wr(OFF_TRIGGER, 32'h3F);
        irq[2] = 1'b1;
        @(negedge clk);
        irq[2] = 1'b0;
        repeat (SYNC_LAT) @(negedge clk);
        chk_mei(0);
        @(negedge clk);
        chk_mei(32'h04);
        rd(OFF_CLAIM, 3);
        chk_mei(32'h04);
        @(negedge clk);
        chk_mei(0);
        rd(OFF_PENDING, 0);
        wr(OFF_COMPLETE, 3);
        rd(OFF_CLAIM, 0);
        rd(OFF_PENDING, 0);
        chk_mei(0);

        phase = "claim_race";
        pulse(6'h01);
        chk_mei(32'h01);
        irq[0] = 1'b1;
        repeat (SYNC_LAT) begin
            @(negedge clk);
            irq[0] = 1'b0;
        end
        rd(OFF_CLAIM, 1);
        irq[0] = 1'b0;
        rd(OFF_PENDING, 32'h01);
        chk_mei(0);
        wr(OFF_COMPLETE, 1);
        chk_mei(0);
        @(negedge clk);
        chk_mei(32'h01);
        rd(OFF_CLAIM, 1);
        wr(OFF_COMPLETE, 1);
        rd(OFF_PENDING, 0);

        phase = "bad_cmp";
        pulse(6'h08);
        chk_mei(32'h08);
        wr(OFF_COMPLETE, 7);
        wr(OFF_COMPLETE, 4);
        rd(OFF_PENDING, 32'h08);
        chk_mei(32'h08);
        rd(OFF_CLAIM, 4);
        wr(OFF_COMPLETE, 32'h24);
        wr(OFF_COMPLETE, 0);
        pulse(6'h08);
        chk_mei(0);
        rd(OFF_PENDING, 32'h08);
        rd(OFF_CLAIM, 0);
        wr(OFF_COMPLETE, 4);
        chk_mei(0);
        @(negedge clk);
        chk_mei(32'h08);
        rd(OFF_CLAIM, 4);
        wr(OFF_COMPLETE, 4);
        rd(OFF_PENDING, 0);

        phase = "w1c";
        pulse(6'h03);
        rd(OFF_PENDING, 32'h03);
        wr(OFF_PENDING, 32'h01);
        rd(OFF_PENDING, 32'h02);
        wr(OFF_TRIGGER, 32'h3D);
        rd(OFF_PENDING, 32'h02);
        wr(OFF_PENDING, 32'h02);
        rd(OFF_PENDING, 32'h02);
        wr(OFF_TRIGGER, 32'hFFFF_FFFF);
        rd(4'h5, 32'h3F);
        wr(OFF_PENDING, 32'hFFFF_FFFF);
        rd(OFF_PENDING, 0);
        rd(OFF_COMPLETE, 0);

        phase = "level";
        wr(OFF_TRIGGER, 0);
        irq = 6'h12;
        repeat (SYNC_LAT + 2) @(negedge clk);
        chk_mei(32'h12);
        rd(OFF_CLAIM, 2);
        rd(OFF_CLAIM, 5);
        rd(OFF_CLAIM, 0);
        rd(OFF_PENDING, 32'h12);
        chk_mei(0);
        wr(OFF_COMPLETE, 2);
        chk_mei(0);
        @(negedge clk);
        chk_mei(32'h02);

        phase = "rst_claim";
        en    = 1'b1;
        we    = 1'b0;
        addr  = OFF_CLAIM;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_rdata", rdata, 0);
        chk_mei(0);
        en  = 1'b0;
        irq = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(OFF_PENDING, 0);
        rd(OFF_TRIGGER, 0);
        rd(OFF_CLAIM, 0);
        chk_mei(0);

        phase = "end";
        repeat (2) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
